// File: rtl/sram_pkg.sv
// Shared state encoding and sizing helpers for the SRAM bank controller.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BUSY  = 2'd2
   } state_e;

   function automatic int lane_count(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port DEPTH x DATA_W storage, per-byte write enables, combinational read.
// Writes land on the clock edge; rdata_o follows addr_i within the cycle.
module sram_array
   import sram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   localparam int NB    = lane_count(DATA_W),
   localparam int IDX_W = idx_width(DEPTH)
) (
   input  logic              clk_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [NB-1:0]     be_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: valid/ready request, response pulse LAT cycles after acceptance.
// One request in flight; req_ready drops while busy or zero-filling after reset.
module sram_bank_ctrl
   import sram_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 512,
   parameter int ADDR_W       = 32,
   parameter int BASE_ADDR    = 1024,
   parameter int LAT          = 3,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   input  logic [DATA_W/8-1:0]    req_be,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   busy_clear
);

   localparam int NB    = lane_count(DATA_W);
   localparam int IDX_W = idx_width(DEPTH);
   localparam int CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;

   logic               we_q, err_q;
   logic [IDX_W-1:0]   idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [NB-1:0]      be_q;

   logic               rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0]  rsp_rdata_q;

   logic [ADDR_W-1:0]  base_a, off, word_a;
   logic               dec_err;
   logic [IDX_W-1:0]   dec_idx;

   logic               accept, fire;
   logic               r_we, r_err;
   logic [IDX_W-1:0]   r_idx;
   logic [DATA_W-1:0]  r_wdata;
   logic [NB-1:0]      r_be;

   logic [IDX_W-1:0]   mem_addr;
   logic [NB-1:0]      mem_be;
   logic [DATA_W-1:0]  mem_wdata, mem_rdata;

   assign base_a  = ADDR_W'(BASE_ADDR);
   assign off     = req_addr - base_a;
   assign word_a  = off / ADDR_W'(NB);
   assign dec_err = (req_addr < base_a) || ((off % ADDR_W'(NB)) != '0) ||
                    (word_a >= ADDR_W'(DEPTH));
   assign dec_idx = word_a[IDX_W-1:0];

   assign accept = req_valid && req_ready;

   // With LAT=1 the response edge is the acceptance edge, so use the live request.
   assign r_we    = (LAT == 1) ? req_we    : we_q;
   assign r_err   = (LAT == 1) ? dec_err   : err_q;
   assign r_idx   = (LAT == 1) ? dec_idx   : idx_q;
   assign r_wdata = (LAT == 1) ? req_wdata : wdata_q;
   assign r_be    = (LAT == 1) ? req_be    : be_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         cnt_q     <= '0;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (accept && (LAT > 1)) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_W'(LAT - 2);
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      busy_clear = 1'b0;
      fire       = 1'b0;
      mem_addr   = r_idx;
      mem_be     = '0;
      mem_wdata  = r_wdata;
      case (state_q)
         ST_CLEAR: begin
            busy_clear = 1'b1;
            mem_addr   = clr_idx_q;
            mem_wdata  = '0;
            mem_be     = rst ? '0 : '1;
         end
         ST_IDLE: begin
            req_ready = !rst;
            fire      = (LAT == 1) && req_valid && !rst;
         end
         ST_BUSY: begin
            fire = (cnt_q == '0) && !rst;
         end
         default: ;
      endcase
      if (fire && r_we && !r_err) begin
         mem_be = r_be;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         err_q   <= dec_err;
         idx_q   <= dec_idx;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   // rdata/err only move on a response so they hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= fire;
         if (fire) begin
            rsp_err_q   <= r_err;
            rsp_rdata_q <= (r_we || r_err) ? '0 : mem_rdata;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   sram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i   (clk),
      .addr_i  (mem_addr),
      .be_i    (mem_be),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: three instances (LAT3/clear, LAT3/no-clear, LAT1/clear) vs. a word-array model.
module tb_sram_bank_ctrl;

   logic              clk;
   logic [2:0]        rst_v, vld_v, rdy_v, rspv_v, err_v, busy_v;
   logic [2:0][31:0]  rdata_v;
   logic              req_we;
   logic [31:0]       req_addr, req_wdata;
   logic [3:0]        req_be;
   logic [31:0]       mdl [3][512];
   int                n_checks = 0;
   int                n_pass   = 0;

   sram_bank_ctrl #(.LAT(3), .CLEAR_ON_RST(1)) u_dut_a (
      .clk(clk), .rst(rst_v[0]), .req_valid(vld_v[0]), .req_ready(rdy_v[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rspv_v[0]), .rsp_rdata(rdata_v[0]), .rsp_err(err_v[0]), .busy_clear(busy_v[0]));

   sram_bank_ctrl #(.LAT(3), .CLEAR_ON_RST(0)) u_dut_b (
      .clk(clk), .rst(rst_v[1]), .req_valid(vld_v[1]), .req_ready(rdy_v[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rspv_v[1]), .rsp_rdata(rdata_v[1]), .rsp_err(err_v[1]), .busy_clear(busy_v[1]));

   sram_bank_ctrl #(.LAT(1), .CLEAR_ON_RST(1)) u_dut_c (
      .clk(clk), .rst(rst_v[2]), .req_valid(vld_v[2]), .req_ready(rdy_v[2]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rspv_v[2]), .rsp_rdata(rdata_v[2]), .rsp_err(err_v[2]), .busy_clear(busy_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int s);
      return (s == 2) ? 1 : 3;
   endfunction

   // Reference: byte-addressed window of 512 words starting at 1024, 4-byte stride.
   task automatic model_req(input int s, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] exp_d, output logic exp_e);
      int idx;
      if (addr < 1024 || ((addr - 1024) % 4) != 0 || ((addr - 1024) / 4) >= 512) begin
         exp_e = 1'b1;
         exp_d = 32'h0;
      end else begin
         idx   = int'((addr - 1024) / 4);
         exp_e = 1'b0;
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_d = 32'h0;
         end else begin
            exp_d = mdl[s][idx];
         end
      end
   endtask

   task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input string tag);
      logic [31:0] exp_d;
      logic        exp_e;
      int          k;
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wd; req_be = be; vld_v[s] = 1'b1;
      k = 0;
      while (rdy_v[s] !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (rdy_v[s] !== 1'b1) begin
         $display("FAIL %s accept timeout: req_ready=%b want 1", tag, rdy_v[s]);
         vld_v[s] = 1'b0;
         return;
      end
      n_pass++;
      model_req(s, we, addr, wd, be, exp_d, exp_e);
      @(posedge clk);
      #1;
      vld_v[s] = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);
      k = 0;
      while (rspv_v[s] !== 1'b1 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_checks++;
      if (rspv_v[s] !== 1'b1 || k != lat_of(s) - 1)
         $display("FAIL %s latency: edges=%0d valid=%b want %0d", tag, k, rspv_v[s], lat_of(s) - 1);
      else n_pass++;
      n_checks++;
      if (err_v[s] !== exp_e) $display("FAIL %s rsp_err: got %b want %b", tag, err_v[s], exp_e);
      else n_pass++;
      n_checks++;
      if (rdata_v[s] !== exp_d) $display("FAIL %s rsp_rdata: got %h want %h", tag, rdata_v[s], exp_d);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (rspv_v[s] !== 1'b0 || rdata_v[s] !== exp_d || err_v[s] !== exp_e)
         $display("FAIL %s pulse/hold: valid=%b rdata=%h err=%b want 0 %h %b",
                  tag, rspv_v[s], rdata_v[s], err_v[s], exp_d, exp_e);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_v = '1; vld_v = '0;
      req_we = 1'b0; req_addr = 32'd1024; req_wdata = '0; req_be = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (rdy_v[s] !== 1'b0 || rspv_v[s] !== 1'b0)
            $display("FAIL reset_ctl[%0d]: ready=%b valid=%b want 0 0", s, rdy_v[s], rspv_v[s]);
         else n_pass++;
         n_checks++;
         if (rdata_v[s] !== 32'h0 || err_v[s] !== 1'b0)
            $display("FAIL reset_rsp[%0d]: rdata=%h err=%b want 0 0", s, rdata_v[s], err_v[s]);
         else n_pass++;
      end
   endtask

   task automatic test_zero_fill();
      int k;
      bit busy_ok;
      @(negedge clk);
      rst_v = '0;
      k = 0; busy_ok = 1'b1;
      while (rdy_v[0] !== 1'b1 && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
         if (rdy_v[0] !== 1'b1 && busy_v[0] !== 1'b1) busy_ok = 1'b0;
      end
      n_checks++;
      if (k != 512) $display("FAIL fill_cycles: got %0d want 512", k); else n_pass++;
      n_checks++;
      if (!busy_ok || busy_v[0] !== 1'b0) $display("FAIL fill_busy: held=%b end=%b want 1 0", busy_ok, busy_v[0]);
      else n_pass++;
      n_checks++;
      if (rdy_v[2] !== 1'b1 || busy_v[1] !== 1'b0 || rdy_v[1] !== 1'b1)
         $display("FAIL fill_others: c_ready=%b b_busy=%b b_ready=%b want 1 0 1", rdy_v[2], busy_v[1], rdy_v[1]);
      else n_pass++;
      for (int i = 0; i < 512; i++) begin
         mdl[0][i] = 32'h0;
         mdl[2][i] = 32'h0;
      end
      do_req(0, 1'b0, 32'd1024, 32'h0, 4'h0, "fill_read");
   endtask

   task automatic test_latency();
      do_req(0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'hF, "lat_wr");
      do_req(0, 1'b0, 32'd1028, 32'h0, 4'h0, "lat_rd");
   endtask

   task automatic test_byte_en();
      do_req(0, 1'b1, 32'd1032, 32'h11223344, 4'hF, "be_init");
      do_req(0, 1'b1, 32'd1032, 32'hAABBCCDD, 4'b0101, "be_wr");
      do_req(0, 1'b0, 32'd1032, 32'h0, 4'hF, "be_rd");
      n_checks++;
      if (rdata_v[0] !== 32'h11BB33DD) $display("FAIL be_merge: got %h want 11bb33dd", rdata_v[0]);
      else n_pass++;
      do_req(0, 1'b1, 32'd1032, 32'hFFFFFFFF, 4'h0, "be_zero_wr");
      do_req(0, 1'b0, 32'd1032, 32'h0, 4'h0, "be_zero_rd");
   endtask

   task automatic test_errors();
      do_req(0, 1'b1, 32'd1024, 32'hCAFE0001, 4'hF, "err_seed0");
      do_req(0, 1'b0, 32'd1020, 32'h0, 4'hF, "err_below");
      do_req(0, 1'b1, 32'd1024 + 32'd2048, 32'h12345678, 4'hF, "err_above");
      do_req(0, 1'b1, 32'd1026, 32'h87654321, 4'hF, "err_misalign");
      do_req(0, 1'b0, 32'd1024, 32'h0, 4'h0, "err_chk0");
      do_req(0, 1'b0, 32'd1028, 32'h0, 4'h0, "err_chk1");
   endtask

   task automatic test_back_to_back(input int s);
      int          sent, cyc;
      int          times[$];
      bit          r, err_seen;
      logic [31:0] d;
      logic        e;
      sent = 0; cyc = 0; err_seen = 1'b0;
      while (cyc < 40) begin
         @(negedge clk);
         if (sent < 4) begin
            req_we = 1'b1; req_addr = 32'd1024 + 32'(4 * (40 + sent));
            req_wdata = $urandom; req_be = 4'hF; vld_v[s] = 1'b1;
         end else begin
            vld_v[s] = 1'b0;
         end
         r = rdy_v[s];
         @(posedge clk);
         if (vld_v[s] && r) begin
            model_req(s, req_we, req_addr, req_wdata, req_be, d, e);
            sent++;
         end
         #1;
         cyc++;
         if (rspv_v[s] === 1'b1) begin
            times.push_back(cyc);
            if (err_v[s] !== 1'b0) err_seen = 1'b1;
         end
      end
      vld_v[s] = 1'b0;
      n_checks++;
      if (times.size() != 4 || err_seen)
         $display("FAIL b2b[%0d]_count: responses=%0d err=%b want 4 0", s, times.size(), err_seen);
      else n_pass++;
      for (int i = 1; i < times.size(); i++) begin
         n_checks++;
         if (times[i] - times[i-1] != lat_of(s))
            $display("FAIL b2b[%0d]_spacing: got %0d want %0d", s, times[i] - times[i-1], lat_of(s));
         else n_pass++;
      end
      do_req(s, 1'b0, 32'd1024 + 32'd160, 32'h0, 4'h0, "b2b_rd0");
      do_req(s, 1'b0, 32'd1024 + 32'd172, 32'h0, 4'h0, "b2b_rd3");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'd1020 - 32'(4 * $urandom_range(0, 3));
            1:       a = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            2:       a = 32'd1024 + 32'(4 * (512 + $urandom_range(0, 7)));
            default: a = 32'd1024 + 32'(4 * $urandom_range(0, 31));
         endcase
         do_req(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
      end
   endtask

   task automatic test_reset_midop();
      bit seen, r;
      do_req(1, 1'b1, 32'd1040, 32'h1234ABCD, 4'hF, "mid_seed");
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'd1040; req_wdata = 32'h5; req_be = 4'hF; vld_v[1] = 1'b1;
      r = rdy_v[1];
      @(posedge clk);
      #1;
      vld_v[1] = 1'b0;
      n_checks++;
      if (r !== 1'b1) $display("FAIL mid_accept: ready=%b want 1", r); else n_pass++;
      @(negedge clk);
      rst_v[1] = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (rspv_v[1] !== 1'b0) seen = 1'b1;
      end
      @(negedge clk);
      rst_v[1] = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (rspv_v[1] !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL mid_no_rsp: rsp_valid=1 want 0"); else n_pass++;
      do_req(1, 1'b0, 32'd1040, 32'h0, 4'h0, "mid_rd");
   endtask

   task automatic test_clear_restart();
      int k;
      bit busy_ok;
      do_req(2, 1'b1, 32'd1024, 32'hFFFFFFFF, 4'hF, "clr_seed0");
      do_req(2, 1'b1, 32'd1024 + 32'd2044, 32'hA5A5A5A5, 4'hF, "clr_seed1");
      @(negedge clk); rst_v[2] = 1'b1;
      @(negedge clk); rst_v[2] = 1'b0;
      busy_ok = 1'b1;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (busy_v[2] !== 1'b1 || rdy_v[2] !== 1'b0) busy_ok = 1'b0;
      end
      n_checks++;
      if (!busy_ok) $display("FAIL clr_busy: busy/ready wrong during fill"); else n_pass++;
      @(negedge clk); rst_v[2] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_v[2] = 1'b0;
      k = 0;
      while (rdy_v[2] !== 1'b1 && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_checks++;
      if (k != 512) $display("FAIL clr_restart: got %0d want 512", k); else n_pass++;
      for (int i = 0; i < 512; i++) mdl[2][i] = 32'h0;
      do_req(2, 1'b0, 32'd1024, 32'h0, 4'h0, "clr_rd0");
      do_req(2, 1'b0, 32'd1024 + 32'd2044, 32'h0, 4'h0, "clr_rd1");
   endtask

   initial begin
      test_reset();
      test_zero_fill();
      test_latency();
      test_byte_en();
      test_errors();
      test_back_to_back(0);
      test_random();
      test_reset_midop();
      test_clear_restart();
      test_back_to_back(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
